// File: rtl/flag_timer.sv
// Programmable countdown timer driven by the chip's free-running uS/mS/100mS pulses.
// Start/busy/done handshake, one-shot or periodic, with a selectable time unit.
module flag_timer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 refclk,
  input  logic                 rst_n,
  input  logic                 uS_Flag,
  input  logic                 mS_Flag,
  input  logic                 hundredmS_Flag,
  input  logic                 start,
  input  logic                 cancel,
  input  logic [1:0]           unit_sel,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 periodic,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] remaining
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    UNIT_US    = 2'd0,
    UNIT_MS    = 2'd1,
    UNIT_100MS = 2'd2,
    UNIT_CLK   = 2'd3
  } unit_t;

  state_t               state, stateNext;
  logic [CNT_WIDTH-1:0] cnt, cntNext;
  logic [CNT_WIDTH-1:0] reloadR, reloadNext;
  unit_t                unitR, unitNext;
  logic                 periodicR, periodicNext;
  logic                 doneR, doneNext;
  logic                 tick;

  // The unit latched at start picks which time-base pulse advances the count.
  always_comb begin
    unique case (unitR)
      UNIT_US:    tick = uS_Flag;
      UNIT_MS:    tick = mS_Flag;
      UNIT_100MS: tick = hundredmS_Flag;
      UNIT_CLK:   tick = 1'b1;
      default:    tick = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every next-state value is defaulted first so no path through the
    // if/else chain below can leave one unassigned and infer a latch.
    stateNext    = state;
    cntNext      = cnt;
    reloadNext   = reloadR;
    unitNext     = unitR;
    periodicNext = periodicR;
    doneNext     = 1'b0;

    if (cancel) begin
      stateNext = IDLE;
      cntNext   = '0;
    end else if (start) begin
      if (load_val != '0) begin
        stateNext    = RUN;
        cntNext      = load_val;
        reloadNext   = load_val;
        unitNext     = unit_t'(unit_sel);
        periodicNext = periodic;
      end else begin
        // A zero-length request completes immediately without ever running.
        stateNext = IDLE;
        cntNext   = '0;
        doneNext  = 1'b1;
      end
    end else if (state == RUN && tick) begin
      if (cnt > CNT_WIDTH'(1)) begin
        cntNext = cnt - CNT_WIDTH'(1);
      end else begin
        doneNext = 1'b1;
        if (periodicR) begin
          cntNext = reloadR;
        end else begin
          stateNext = IDLE;
          cntNext   = '0;
        end
      end
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      reloadR   <= '0;
      unitR     <= UNIT_US;
      periodicR <= 1'b0;
      doneR     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // same pre-edge values, independent of statement order.
      state     <= stateNext;
      cnt       <= cntNext;
      reloadR   <= reloadNext;
      unitR     <= unitNext;
      periodicR <= periodicNext;
      doneR     <= doneNext;
    end
  end

  assign busy      = (state == RUN);
  assign done      = doneR;
  assign remaining = cnt;

endmodule

// File: tb/tb_flag_timer.sv
// Self-checking bench for flag_timer: randomized and directed stimulus, an
// interval-level reference model and a per-cycle scoreboard with monitor.
module tb_flag_timer;

  localparam int CW    = 16;
  // Time base is scaled down so intervals fit a short run.
  localparam int US_P  = 12;
  localparam int MS_P  = 120;
  localparam int HMS_P = 1200;

  logic          refclk = 1'b0;
  logic          rst_n;
  logic          uS_Flag, mS_Flag, hundredmS_Flag;
  logic          start, cancel, periodic;
  logic [1:0]    unit_sel;
  logic [CW-1:0] load_val;
  logic          busy, done;
  logic [CW-1:0] remaining;

  flag_timer #(.CNT_WIDTH(CW)) dut (
    .refclk(refclk), .rst_n(rst_n),
    .uS_Flag(uS_Flag), .mS_Flag(mS_Flag), .hundredmS_Flag(hundredmS_Flag),
    .start(start), .cancel(cancel), .unit_sel(unit_sel), .load_val(load_val),
    .periodic(periodic), .busy(busy), .done(done), .remaining(remaining)
  );

  always #5 refclk = ~refclk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an interval is a length in units and a count of units elapsed.
  typedef struct {
    bit busy;
    bit done;
    int rem;
  } exp_t;

  exp_t expQ[$];
  bit   mActive, mPeriodic, mDone;
  int   mLen, mElapsed, mUnit;

  function automatic void modelReset();
    mActive = 0; mPeriodic = 0; mDone = 0;
    mLen = 0; mElapsed = 0; mUnit = 0;
  endfunction

  function automatic void modelStep(input bit st, input bit ca, input int us, input int lv, input bit per);
    bit unitPassed;
    unitPassed = (mUnit == 0) ? uS_Flag : (mUnit == 1) ? mS_Flag :
                 (mUnit == 2) ? hundredmS_Flag : 1'b1;
    mDone = 0;
    if (ca) begin
      mActive = 0;
    end else if (st) begin
      if (lv == 0) begin
        mActive = 0;
        mDone   = 1;
      end else begin
        mActive = 1; mLen = lv; mElapsed = 0; mUnit = us; mPeriodic = per;
      end
    end else if (mActive && unitPassed) begin
      mElapsed++;
      if (mElapsed == mLen) begin
        mDone    = 1;
        mElapsed = 0;
        mActive  = mPeriodic;
      end
    end
  endfunction

  // One clock cycle: record what the DUT should show now, then apply new inputs.
  task automatic driveCycle(input bit st, input bit ca, input int us, input int lv, input bit per);
    exp_t e;
    @(posedge refclk); #1;
    e.busy = mActive;
    e.done = mDone;
    e.rem  = mActive ? (mLen - mElapsed) : 0;
    expQ.push_back(e);
    start          = st;
    cancel         = ca;
    unit_sel       = us[1:0];
    load_val       = lv[CW-1:0];
    periodic       = per;
    uS_Flag        = (cyc % US_P) == 5;
    mS_Flag        = (cyc % MS_P) == 7;
    hundredmS_Flag = (cyc % HMS_P) == 11;
    modelStep(st, ca, us, lv, per);
    cyc++;
  endtask

  task automatic idle();
    driveCycle(0, 0, $urandom_range(0, 3), $urandom_range(0, 40), $urandom_range(0, 1));
  endtask

  // Monitor: compares DUT outputs against the scoreboard every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge refclk);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        check("sb_busy", busy, e.busy);
        check("sb_done", done, e.done);
        check("sb_remaining", remaining, e.rem);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int doneCyc[$];
    int startCyc, busyLow, pulses, k;
    bit seen;

    modelReset();
    rst_n = 1'b0;
    start = 0; cancel = 0; unit_sel = 0; load_val = '0; periodic = 0;
    uS_Flag = 0; mS_Flag = 0; hundredmS_Flag = 0;
    #12;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_remaining", remaining, 0);
    #10 rst_n = 1'b1;

    // Asynchronous reset in the middle of a run.
    driveCycle(1, 0, 3, 5, 0);
    idle(); idle();
    check("pre_reset_busy", busy, 1);
    @(posedge refclk); #3;
    rst_n = 1'b0;
    #1;
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    check("async_remaining", remaining, 0);
    expQ.delete();
    modelReset();
    start = 0; cancel = 0;
    #20 rst_n = 1'b1;
    repeat (4) idle();
    check("post_reset_busy", busy, 0);

    // One-shot raw clock count: remaining 4,3,2,1 then done with busy low.
    driveCycle(1, 0, 3, 4, 0);
    for (int i = 0; i < 5; i++) begin
      idle();
      check("raw_busy", busy, (i < 4) ? 1 : 0);
      check("raw_remaining", remaining, (i < 4) ? 4 - i : 0);
      check("raw_done", done, (i == 4) ? 1 : 0);
    end
    idle();
    check("raw_done_width", done, 0);

    // Periodic ms: first interval within bounds, later intervals exact.
    repeat (3) idle();
    driveCycle(1, 0, 1, 3, 1);
    startCyc = cyc - 1;
    busyLow = 0;
    doneCyc.delete();
    for (int i = 0; i < 4 * 3 * MS_P + 400 && doneCyc.size() < 4; i++) begin
      idle();
      if (busy !== 1'b1) busyLow++;
      if (done === 1'b1) doneCyc.push_back(cyc - 1);
    end
    check("per_done_count", doneCyc.size(), 4);
    check("per_busy_held", busyLow, 0);
    if (doneCyc.size() == 4) begin
      k = doneCyc[0] - startCyc;
      check("per_first_in_range", (k >= 2 * MS_P + 2 && k <= 3 * MS_P + 1), 1);
      for (int i = 1; i < 4; i++) check("per_gap", doneCyc[i] - doneCyc[i-1], 3 * MS_P);
    end
    driveCycle(0, 1, 0, 0, 0);
    idle();
    check("per_cancel_busy", busy, 0);

    // Zero load: immediate single-cycle done, never busy.
    driveCycle(1, 0, 2, 0, 0);
    idle();
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_remaining", remaining, 0);
    idle();
    check("zero_done_width", done, 0);

    // Cancel beats start and tick at the terminal count.
    driveCycle(1, 0, 3, 3, 0);
    for (int i = 0; i < 10 && remaining != 1; i++) idle();
    check("cs_reached_one", remaining, 1);
    driveCycle(1, 1, 3, 7, 0);
    idle();
    check("cs_done", done, 0);
    check("cs_busy", busy, 0);
    check("cs_remaining", remaining, 0);

    // Start beats the terminal tick: restart without done.
    driveCycle(1, 0, 3, 3, 0);
    for (int i = 0; i < 10 && remaining != 1; i++) idle();
    driveCycle(1, 0, 3, 6, 0);
    idle();
    check("rs_done", done, 0);
    check("rs_remaining", remaining, 6);
    check("rs_busy", busy, 1);
    for (int i = 0; i < 20 && busy; i++) idle();
    check("rs_finished", busy, 0);

    // 100 ms unit with restart at remaining 1.
    driveCycle(1, 0, 2, 2, 0);
    for (int i = 0; i < 2 * HMS_P + 10 && remaining != 1; i++) idle();
    check("hms_reached_one", remaining, 1);
    driveCycle(1, 0, 2, 10, 0);
    idle();
    check("hms_restart_done", done, 0);
    check("hms_restart_rem", remaining, 10);
    pulses = hundredmS_Flag;
    seen = 0;
    for (int i = 0; i < 11 * HMS_P + 10; i++) begin
      idle();
      if (done) begin seen = 1; break; end
      pulses += hundredmS_Flag;
    end
    check("hms_done_seen", seen, 1);
    check("hms_pulses_in_range", (pulses >= 9 && pulses <= 10), 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 8000; i++) begin
      int us, lv;
      bit st, ca;
      us = $urandom_range(0, 3);
      lv = (us == 3) ? $urandom_range(0, 30) : (us == 0) ? $urandom_range(0, 10) :
           (us == 1) ? $urandom_range(0, 4) : $urandom_range(0, 2);
      st = ($urandom_range(0, 39) == 0);
      ca = ($urandom_range(0, 149) == 0);
      driveCycle(st, ca, us, lv, $urandom_range(0, 1));
    end
    idle();

    @(negedge refclk); #1;
    check("queue_drained", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
